// File: rtl/integ_pkg.sv
// Shared types and default sizing for the streaming integral-image generator.
package integ_pkg;

    // Frame-level control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } integ_state_t;

    // Default integral width, maximum row length and linear address width.
    localparam int OUT_W_DEF  = 24;
    localparam int MAX_W_DEF  = 1024;
    localparam int ADDR_W_DEF = 17;

    // Narrowest accepted row.  At two columns or more, the line-buffer read and
    // write never target the same column on the same edge.
    localparam int MIN_W = 2;

    // Line-buffer address width for a given maximum row length.
    function automatic int lb_addr_w(input int max_w);
        return (max_w > 1) ? $clog2(max_w) : 1;
    endfunction

endpackage

// File: rtl/integ_line_buf.sv
// One-row line buffer holding the previous row's integral values.
// Simple dual-port RAM: one synchronous read port and one write port.
// The array is not reset; stale contents are masked by the caller on row 0.
module integ_line_buf
    import integ_pkg::*;
#(
    parameter int DEPTH = MAX_W_DEF,
    parameter int WIDTH = OUT_W_DEF,
    parameter int AW    = lb_addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port plus registered read; read data holds until the next read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/integral_image_gen.sv
// Streaming summed-area-table generator.
// Consumes a raster-order 8-bit pixel stream and emits, per pixel, the integral
// I(x,y) together with its linear address y*width + x.  The two-stage pipeline
// works as follows.  The acceptance edge latches the pixel and issues the
// line-buffer read.  The next advancing edge forms I, drives the output
// registers and writes I back to the line buffer.
// Optional build macro INTEG_SAT_EN: saturate sums at 2^OUT_W-1 and raise
// sat_flag.  When it is undefined, sums wrap modulo 2^OUT_W and sat_flag is 0.
module integral_image_gen
    import integ_pkg::*;
#(
    parameter int OUT_W  = OUT_W_DEF,
    parameter int MAX_W  = MAX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       img_width,
    input  logic [15:0]       img_height,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              sat_flag
);

    localparam int LB_AW = lb_addr_w(MAX_W);

    // OUT_W+1 bit sum so a carry out of the integral width is visible.
    function automatic logic [OUT_W:0] f_wide_add(input logic [OUT_W-1:0] a,
                                                  input logic [OUT_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Fold a wide sum back to OUT_W bits: clamp or wrap depending on the build.
    function automatic logic [OUT_W-1:0] f_fold(input logic [OUT_W:0] s);
`ifdef INTEG_SAT_EN
        return s[OUT_W] ? {OUT_W{1'b1}} : s[OUT_W-1:0];
`else
        return s[OUT_W-1:0];
`endif
    endfunction

    // Frame control and counters
    integ_state_t      r_state;
    logic [15:0]       r_width;
    logic [15:0]       r_height;
    logic [15:0]       r_x;
    logic [15:0]       r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_cfg_err;

    // Stage p0: accepted pixel and its position
    logic              r_vld_p0;
    logic [7:0]        r_pix_p0;
    logic [LB_AW-1:0]  r_col_p0;
    logic              r_row0_p0;
    logic              r_col0_p0;
    logic [ADDR_W-1:0] r_addr_p0;

    // Stage p1: registered result
    logic              r_vld_p1;
    logic [OUT_W-1:0]  r_data_p1;
    logic [ADDR_W-1:0] r_addr_p1;

    logic [OUT_W-1:0]  r_rowsum;

    logic              w_advance;
    logic              w_pix_ready;
    logic              w_accept;
    logic              w_x_wrap;
    logic              w_last_pix;
    logic [31:0]       w_area;
    logic              w_cfg_ok;
    logic              w_start_ok;
    logic              w_final;
    logic              w_p1_load;
    logic [OUT_W-1:0]  w_lb_rd_data;
    logic [OUT_W-1:0]  w_above;
    logic [OUT_W:0]    w_rowsum_sum;
    logic [OUT_W-1:0]  w_rowsum_new;
    logic [OUT_W:0]    w_integ_sum;
    logic [OUT_W-1:0]  w_integ;

    // Handshake: the whole pipeline moves whenever the output slot is free.
    assign w_advance   = !r_vld_p1 || out_ready;
    assign w_pix_ready = (r_state == RUN) && w_advance;
    assign w_accept    = pix_valid && w_pix_ready;
    assign w_p1_load   = w_advance && r_vld_p0;

    assign w_x_wrap   = (r_x == r_width - 16'd1);
    assign w_last_pix = w_x_wrap && (r_y == r_height - 16'd1);

    // Frame geometry check; the product is only evaluated at start, the
    // per-pixel address itself is a plain counter.
    assign w_area     = 32'(img_width) * 32'(img_height);
    assign w_cfg_ok   = (img_width >= 16'(MIN_W))
                     && (32'(img_width) <= 32'(MAX_W))
                     && (img_height != 16'd0)
                     && ({1'b0, w_area} <= (33'd1 << ADDR_W));
    assign w_start_ok = (r_state == IDLE) && start && w_cfg_ok;

    // Last result leaves when p0 is empty and the held output is consumed.
    assign w_final = (r_state == DRAIN) && r_vld_p1 && out_ready && !r_vld_p0;

    // Integral arithmetic for the pixel in p0.
    assign w_above      = r_row0_p0 ? {OUT_W{1'b0}} : w_lb_rd_data;
    assign w_rowsum_sum = r_col0_p0 ? (OUT_W+1)'(r_pix_p0)
                                    : f_wide_add(r_rowsum, OUT_W'(r_pix_p0));
    assign w_rowsum_new = f_fold(w_rowsum_sum);
    assign w_integ_sum  = f_wide_add(w_rowsum_new, w_above);
    assign w_integ      = f_fold(w_integ_sum);

    integ_line_buf #(
        .DEPTH (MAX_W),
        .WIDTH (OUT_W),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk       (clk),
        .i_rd_en   (w_accept),
        .i_rd_addr (r_x[LB_AW-1:0]),
        .o_rd_data (w_lb_rd_data),
        .i_wr_en   (w_p1_load),
        .i_wr_addr (r_col_p0),
        .i_wr_data (w_integ)
    );

    // Frame FSM: start checking, raster counters, busy/done/cfg_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_width   <= 16'd0;
            r_height  <= 16'd0;
            r_x       <= 16'd0;
            r_y       <= 16'd0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_state   <= RUN;
                            r_busy    <= 1'b1;
                            r_cfg_err <= 1'b0;
                            r_width   <= img_width;
                            r_height  <= img_height;
                            r_x       <= 16'd0;
                            r_y       <= 16'd0;
                            r_addr    <= '0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_x_wrap) begin
                            r_x <= 16'd0;
                            r_y <= r_y + 16'd1;
                        end else begin
                            r_x <= r_x + 16'd1;
                        end
                        if (w_last_pix) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_final) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pipeline valids and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_addr_p1 <= '0;
        end else if (w_advance) begin
            r_vld_p0 <= w_accept;
            r_vld_p1 <= r_vld_p0;
            if (r_vld_p0) begin
                r_data_p1 <= w_integ;
                r_addr_p1 <= r_addr_p0;
            end
        end
    end

    // Stage p0 capture and running row sum; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pix_p0  <= pix_data;
            r_col_p0  <= r_x[LB_AW-1:0];
            r_row0_p0 <= (r_y == 16'd0);
            r_col0_p0 <= (r_x == 16'd0);
            r_addr_p0 <= r_addr;
        end
        if (w_p1_load) begin
            r_rowsum <= w_rowsum_new;
        end
    end

`ifdef INTEG_SAT_EN
    logic r_sat;
    logic w_clamp;

    assign w_clamp = w_rowsum_sum[OUT_W] | w_integ_sum[OUT_W];

    // Sticky clamp indicator, cleared by an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat <= 1'b0;
        end else if (w_start_ok) begin
            r_sat <= 1'b0;
        end else if (w_p1_load && w_clamp) begin
            r_sat <= 1'b1;
        end
    end

    assign sat_flag = r_sat;
`else
    assign sat_flag = 1'b0;
`endif

    assign pix_ready = w_pix_ready;
    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_addr  = r_addr_p1;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule
